// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared types, mode codes and divider helper for period_meter
package period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic MODE_PERIOD = 1'b0;
  localparam logic MODE_HIGH   = 1'b1;

  // Clocks per measurement tick; callers check exactness at elaboration.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with registered rise/fall pulses
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_FPGA,
  input  logic reset,
  input  logic sig_async,
  output logic level,
  output logic rise,
  output logic fall
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_edge_det: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  // Pulses are registered so they line up with the level they announce.
  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_async};
      level_q <= sync_q[SYNC_STAGES-1];
      rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
      fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - period / high-time meter in prescaled ticks with saturation and no-signal flags
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1_000_000,
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock_FPGA,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             overflow,
  output logic             no_signal
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, TICK_HZ);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAXC = {WIDTH{1'b1}};
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

  generate
    if (((CLK_FREQ_HZ % TICK_HZ) != 0) || (DIV < 2)) begin : g_bad_div
      $error("period_meter: CLK_FREQ_HZ must be an exact multiple of TICK_HZ with DIV >= 2");
    end
  endgenerate

  logic sig_level;
  logic rise;
  logic fall;
  logic unused_level;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock_FPGA(clock_FPGA),
    .reset     (reset),
    .sig_async (sig_in),
    .level     (sig_level),
    .rise      (rise),
    .fall      (fall)
  );

  assign unused_level = sig_level;

  state_t           state;
  state_t           state_next;
  logic             mode_q;
  logic [PW-1:0]    prescaler;
  logic [WIDTH-1:0] count;
  logic             sat;

  logic             tick;
  logic [WIDTH-1:0] count_next;
  logic             sat_next;
  logic             start_meas;
  logic             capture;
  logic             clear_cnt;

  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_next = MEASURE;
        MEASURE: if ((mode_q == MODE_HIGH) && fall) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // A period-mode closing rise both captures and starts the next measurement.
  always_comb begin
    start_meas = 1'b0;
    capture    = 1'b0;
    clear_cnt  = 1'b0;
    if (!enable) begin
      clear_cnt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          start_meas = rise;
        end
        MEASURE: begin
          if (mode_q == MODE_PERIOD) begin
            capture    = rise;
            start_meas = rise;
          end else begin
            capture   = fall;
            clear_cnt = fall;
          end
        end
        default: clear_cnt = 1'b1;
      endcase
    end
  end

  assign tick       = (prescaler == PRESC_LAST);
  assign count_next = (tick && (count != MAXC)) ? count + 1'b1 : count;
  assign sat_next   = sat | (tick && (count == MAXC));

  // The capture takes count_next so a tick landing on the closing edge is kept.
  always_ff @(posedge clock_FPGA) begin
    if (reset) begin
      mode_q       <= MODE_PERIOD;
      prescaler    <= '0;
      count        <= '0;
      sat          <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      period_valid <= capture;
      if (capture) begin
        period_out <= count_next;
        overflow   <= sat_next;
      end
      if (start_meas) begin
        mode_q <= mode;
      end
      if (start_meas || clear_cnt) begin
        prescaler <= '0;
        count     <= '0;
        sat       <= 1'b0;
      end else if (state == MEASURE) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
        count     <= count_next;
        sat       <= sat_next;
      end
    end
  end

  assign no_signal = (state == MEASURE) && (count == MAXC);

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - self-checking bench for period_meter with a tick-arithmetic model
module tb_period_meter;

  localparam int DIV_A  = 3;
  localparam int MAXC_A = 4095;

  logic clock_FPGA = 1'b0;
  always #5 clock_FPGA = ~clock_FPGA;

  logic        reset;
  logic        enable;
  logic        mode;
  logic        sig_in;
  logic [11:0] period_out;
  logic        period_valid;
  logic        overflow;
  logic        no_signal;

  logic        sig_b;
  logic        enable_b;
  logic        mode_b;
  logic [11:0] period_out_b;
  logic        period_valid_b;
  logic        overflow_b;
  logic        no_signal_b;

  period_meter #(
    .CLK_FREQ_HZ(3_000_000),
    .TICK_HZ    (1_000_000),
    .WIDTH      (12),
    .SYNC_STAGES(2)
  ) dut (
    .clock_FPGA  (clock_FPGA),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .sig_in      (sig_in),
    .period_out  (period_out),
    .period_valid(period_valid),
    .overflow    (overflow),
    .no_signal   (no_signal)
  );

  period_meter #(
    .CLK_FREQ_HZ(50_000_000),
    .TICK_HZ    (25_000_000),
    .WIDTH      (12),
    .SYNC_STAGES(2)
  ) dut_b (
    .clock_FPGA  (clock_FPGA),
    .reset       (reset),
    .enable      (enable_b),
    .mode        (mode_b),
    .sig_in      (sig_b),
    .period_out  (period_out_b),
    .period_valid(period_valid_b),
    .overflow    (overflow_b),
    .no_signal   (no_signal_b)
  );

  int tests = 0;
  int fails = 0;

  // Model: a detected edge reaches the control logic three clocks after sig_in is sampled;
  // each result is floor(edge spacing / DIV), saturated at MAXC.
  int cyc = 0;
  bit h[4];
  bit m_rise;
  bit m_fall;
  bit m_meas = 0;
  bit m_mode = 0;
  int m_start = 0;
  int m_q;
  bit e_valid = 0;
  int e_out = 0;
  bit e_ovf = 0;
  bit e_nosig = 0;
  int model_val[$];
  bit model_ovf[$];

  always @(posedge clock_FPGA) begin
    cyc++;
    e_valid = 0;
    if (reset) begin
      foreach (h[i]) h[i] = 0;
      m_meas = 0;
      e_out  = 0;
      e_ovf  = 0;
    end else begin
      m_rise = h[2] & ~h[3];
      m_fall = ~h[2] & h[3];
      if (!enable) begin
        m_meas = 0;
      end else if (m_meas && ((!m_mode && m_rise) || (m_mode && m_fall))) begin
        m_q     = (cyc - m_start) / DIV_A;
        e_valid = 1;
        e_out   = (m_q > MAXC_A) ? MAXC_A : m_q;
        e_ovf   = (m_q > MAXC_A);
        model_val.push_back(e_out);
        model_ovf.push_back(e_ovf);
        if (!m_mode) begin
          m_start = cyc;
          m_mode  = mode;
        end else begin
          m_meas = 0;
        end
      end else if (!m_meas && m_rise) begin
        m_meas  = 1;
        m_start = cyc;
        m_mode  = mode;
      end
      h[3] = h[2];
      h[2] = h[1];
      h[1] = h[0];
      h[0] = sig_in;
    end
    e_nosig = m_meas && (((cyc - m_start) / DIV_A) >= MAXC_A);
  end

  bit checking = 0;
  int dut_val[$];
  bit dut_ovf[$];
  int b_valids = 0;

  always @(negedge clock_FPGA) begin
    if (checking) begin
      tests++;
      if (period_valid !== e_valid || period_out !== 12'(e_out) ||
          overflow !== e_ovf || no_signal !== e_nosig) begin
        fails++;
        if (fails <= 10)
          $display("FAIL cycle_check cyc=%0d got v=%b out=%0d ovf=%b ns=%b required v=%b out=%0d ovf=%b ns=%b",
                   cyc, period_valid, period_out, overflow, no_signal, e_valid, e_out, e_ovf, e_nosig);
      end
      if (period_valid === 1'b1) begin
        dut_val.push_back(int'(period_out));
        dut_ovf.push_back(overflow);
      end
      if (period_valid_b === 1'b1) b_valids++;
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock_FPGA);
  endtask

  task automatic pulse(input int high_cyc, input int low_cyc);
    sig_in = 1'b1;
    wait_cyc(high_cyc);
    sig_in = 1'b0;
    wait_cyc(low_cyc);
  endtask

  task automatic restart_idle(input logic new_mode);
    enable = 1'b0;
    wait_cyc(4);
    mode   = new_mode;
    enable = 1'b1;
    wait_cyc(4);
  endtask

  int lit_val[12] = '{1000, 1000, 1000, 300, 300, 300, 4095, 1000, 500, 500, 1000, 300};
  bit lit_ovf[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b_at;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    mode     = 1'b0;
    sig_in   = 1'b0;
    sig_b    = 1'b0;
    enable_b = 1'b1;
    mode_b   = 1'b0;
    wait_cyc(3);
    checking = 1;
    check("reset_period_out", int'(period_out), 0);
    check("reset_valid", int'(period_valid), 0);
    reset  = 1'b0;
    enable = 1'b1;
    wait_cyc(4);

    // 1 kHz square wave, period mode
    repeat (4) pulse(1500, 1500);

    // 30 % duty, high-time mode
    restart_idle(1'b1);
    repeat (3) pulse(900, 2100);

    // 5000 us period saturates, then a normal 1000 us period
    restart_idle(1'b0);
    pulse(7500, 7500);
    check("no_signal_saturated", int'(no_signal), 1);
    pulse(1500, 1500);
    sig_in = 1'b1;
    wait_cyc(10);
    sig_in = 1'b0;
    wait_cyc(20);
    check("no_signal_after_capture", int'(no_signal), 0);

    // reset mid-measurement, then enable drop mid-measurement
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
    check("midreset_period_out", int'(period_out), 0);
    check("midreset_overflow", int'(overflow), 0);
    pulse(750, 750);
    pulse(750, 750);
    enable = 1'b0;
    wait_cyc(10);
    check("disabled_hold_out", int'(period_out), 500);
    enable = 1'b1;
    wait_cyc(4);
    pulse(750, 750);
    pulse(750, 750);

    // mode change mid-period takes effect at the next start edge
    restart_idle(1'b0);
    sig_in = 1'b1;
    wait_cyc(1500);
    sig_in = 1'b0;
    wait_cyc(700);
    mode = 1'b1;
    wait_cyc(800);
    pulse(900, 100);
    mode = 1'b0;
    wait_cyc(20);

    // DIV = 2 instance: rises 7 clocks apart, valid latency from the closing edge
    sig_b = 1'b1;
    wait_cyc(3);
    sig_b = 1'b0;
    wait_cyc(4);
    sig_b = 1'b1;
    b_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock_FPGA);
      if (period_valid_b === 1'b1 && b_at < 0) b_at = i;
    end
    check("divb_valid_latency", b_at, 4);
    check("divb_valid_count", b_valids, 1);
    check("divb_period_out", int'(period_out_b), 3);
    check("divb_overflow", int'(overflow_b), 0);

    check("dut_result_count", dut_val.size(), 12);
    check("model_result_count", model_val.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < dut_val.size()) begin
        check($sformatf("dut_result_%0d", i), dut_val[i], lit_val[i]);
        check($sformatf("dut_ovf_%0d", i), int'(dut_ovf[i]), int'(lit_ovf[i]));
      end
      if (i < model_val.size()) begin
        check($sformatf("model_result_%0d", i), model_val[i], lit_val[i]);
        check($sformatf("model_ovf_%0d", i), int'(model_ovf[i]), int'(lit_ovf[i]));
      end
    end

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
